// File: rtl/popcount_sched.sv
// popcount_sched: round-robin front end for four requesters that share one
// fixed-latency popcount pipeline. It carries the requester ids alongside the
// pipeline and returns results in issue order through a response FIFO. Credit
// gating keeps the FIFO from overflowing.
//
// Ports
//   clk, RST                  clock, asynchronous active-high reset
//   req_valid[3:0]            per-requester request valid
//   req_mask[159:0]           packed 40-bit masks, requester i at [40i+39:40i]
//   req_ready[3:0]            one-hot accept (combinational)
//   pc_in_valid, pc_mask      issue to popcount pipeline (combinational)
//   pc_out_valid, pc_count    result from popcount pipeline
//   rsp_valid/ready/id/count  response stream (FIFO head)
//   busy                      any request in flight or buffered
//   err                       sticky pipeline protocol error
module popcount_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PC_LAT     = 2
) (
    input  logic         clk,
    input  logic         RST,
    input  logic [3:0]   req_valid,
    input  logic [159:0] req_mask,
    output logic [3:0]   req_ready,
    output logic         pc_in_valid,
    output logic [39:0]  pc_mask,
    input  logic         pc_out_valid,
    input  logic [5:0]   pc_count,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [1:0]   rsp_id,
    output logic [5:0]   rsp_count,
    output logic         busy,
    output logic         err
);

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned MASK_W  = 40;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CRED_W  = $clog2(FIFO_DEPTH + PC_LAT + 1);
    localparam int unsigned QUIET_W = $clog2(PC_LAT + 1);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] count;
    } rsp_entry_t;

    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    cand;
    logic               gnt_found;
    logic [CRED_W-1:0]  inflight;
    logic [CRED_W-1:0]  credit;
    logic               xfer;

    logic [PC_LAT-1:0]  tag_vld;
    logic [ID_W-1:0]    tag_id [PC_LAT];

    rsp_entry_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;

    logic [QUIET_W-1:0] quiet;
    logic               quiet_win;
    logic               final_vld;
    logic               mismatch;
    logic               push;
    logic               do_push;
    logic               pop;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'(last_grant + ID_W'(k + 1));
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Credit from registered state only: tags in flight plus FIFO occupancy.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < PC_LAT; k++) begin
            inflight = inflight + CRED_W'(tag_vld[k]);
        end
        credit = inflight + CRED_W'(occ);
    end

    assign xfer = !RST && gnt_found && (credit < CRED_W'(FIFO_DEPTH));

    // Issue side: grant strobe and mask mux toward the popcount pipeline.
    always_comb begin
        req_ready   = '0;
        pc_mask     = '0;
        pc_in_valid = xfer;
        if (xfer) begin
            req_ready = 4'(1) << gnt_idx;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (xfer && (gnt_idx == ID_W'(i))) begin
                pc_mask = req_mask[i*MASK_W +: MASK_W];
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            last_grant <= ID_W'(N_REQ - 1);
        end else if (xfer) begin
            last_grant <= gnt_idx;
        end
    end

    // Id tag shift register aligned with the popcount pipeline latency.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            tag_vld <= '0;
            for (int k = 0; k < PC_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_vld[0] <= xfer;
            tag_id[0]  <= gnt_idx;
            for (int k = 1; k < PC_LAT; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_id[k]  <= tag_id[k-1];
            end
        end
    end

    // Results of pre-reset issues can still emerge for PC_LAT cycles after
    // release; that window is ignored rather than flagged.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            quiet <= QUIET_W'(PC_LAT);
        end else if (quiet != '0) begin
            quiet <= quiet - QUIET_W'(1);
        end
    end

    assign quiet_win = (quiet != '0);
    assign final_vld = tag_vld[PC_LAT-1];
    assign mismatch  = !quiet_win && (pc_out_valid != final_vld);
    assign push      = !quiet_win && pc_out_valid && final_vld;
    assign pop       = (occ != '0) && rsp_ready;
    assign do_push   = push && ((occ != OCC_W'(FIFO_DEPTH)) || pop);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            err <= 1'b0;
        end else if (mismatch) begin
            err <= 1'b1;
        end
    end

    // Response FIFO; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                mem[e] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= '{id: tag_id[PC_LAT-1], count: pc_count};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign rsp_valid = (occ != '0);
    assign rsp_id    = mem[rd_ptr].id;
    assign rsp_count = mem[rd_ptr].count;
    assign busy      = (credit != '0);

endmodule

// File: tb/tb_popcount_sched.sv
// Directed bench for popcount_sched with a behavioural popcount pipeline.
module tb_popcount_sched;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned PC_LAT     = 2;

    localparam logic [39:0] MASK_TAB [4] = '{40'hFF_FFFF_FFFF, 40'h00_0000_0000,
                                             40'h80_0000_0001, 40'h0F_0F0F_0F0F};
    localparam logic [5:0]  EXP_CNT  [4] = '{6'd40, 6'd0, 6'd2, 6'd20};
    localparam int          RR_SEQ   [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

    logic         clk;
    logic         RST;
    logic [3:0]   req_valid;
    logic [159:0] req_mask;
    logic [3:0]   req_ready;
    logic         pc_in_valid;
    logic [39:0]  pc_mask;
    logic         pc_out_valid;
    logic [5:0]   pc_count;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [5:0]   rsp_count;
    logic         busy;
    logic         err;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_q [$];

    popcount_sched #(.FIFO_DEPTH(FIFO_DEPTH), .PC_LAT(PC_LAT)) dut (
        .clk(clk), .RST(RST),
        .req_valid(req_valid), .req_mask(req_mask), .req_ready(req_ready),
        .pc_in_valid(pc_in_valid), .pc_mask(pc_mask),
        .pc_out_valid(pc_out_valid), .pc_count(pc_count),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_count(rsp_count),
        .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Popcount pipeline model; not reset, so pre-reset results still emerge.
    logic [PC_LAT-1:0] pv = '0;
    logic [5:0]        pcnt [PC_LAT];
    logic              inj;
    always @(posedge clk) begin
        pv[0]   <= pc_in_valid;
        pcnt[0] <= 6'($countones(pc_mask));
        for (int k = 1; k < PC_LAT; k++) begin
            pv[k]   <= pv[k-1];
            pcnt[k] <= pcnt[k-1];
        end
    end
    assign pc_out_valid = pv[PC_LAT-1] | inj;
    assign pc_count     = pcnt[PC_LAT-1];

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Expect a grant to requester id this cycle and queue its response.
    task automatic expect_grant(input string tag, input int id);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        #1;
        check_vec({tag, "_ready"}, 64'(req_ready), 64'(oh));
        check_vec({tag, "_pcv"}, 64'(pc_in_valid), 64'd1);
        check_vec({tag, "_pcmask"}, 64'(pc_mask), 64'(MASK_TAB[id]));
        exp_q.push_back({2'(id), EXP_CNT[id]});
    endtask

    // Response scoreboard: every accepted response must match the queue head.
    always @(negedge clk) begin : mon
        logic [7:0] e;
        #2;
        if (!RST && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check_vec("rsp_extra", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_vec("rsp_id", 64'(rsp_id), 64'(e[7:6]));
                check_vec("rsp_count", 64'(rsp_count), 64'(e[5:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        RST       = 1'b1;
        inj       = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        req_mask  = {MASK_TAB[3], MASK_TAB[2], MASK_TAB[1], MASK_TAB[0]};
        repeat (2) @(negedge clk);
        #1;
        check_vec("rst_ready", 64'(req_ready), 64'd0);
        check_vec("rst_pcv", 64'(pc_in_valid), 64'd0);
        check_vec("rst_pcmask", 64'(pc_mask), 64'd0);
        check_vec("rst_rspv", 64'(rsp_valid), 64'd0);
        check_vec("rst_rspid", 64'(rsp_id), 64'd0);
        check_vec("rst_rspcnt", 64'(rsp_count), 64'd0);
        check_vec("rst_busy", 64'(busy), 64'd0);
        check_vec("rst_err", 64'(err), 64'd0);

        // Single request, latency PC_LAT+1.
        @(negedge clk);
        RST = 1'b0; req_valid = 4'b0001; rsp_ready = 1'b1;
        expect_grant("single", 0);
        check_vec("single_busy0", 64'(busy), 64'd0);
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        check_vec("single_busy1", 64'(busy), 64'd1);
        check_vec("single_rspv1", 64'(rsp_valid), 64'd0);
        @(negedge clk); #1;
        check_vec("single_rspv2", 64'(rsp_valid), 64'd0);
        @(negedge clk); #1;
        check_vec("single_rspv3", 64'(rsp_valid), 64'd1);
        @(negedge clk); #1;
        check_vec("single_rspv4", 64'(rsp_valid), 64'd0);
        check_vec("single_idle", 64'(busy), 64'd0);

        // Round robin with all requesters valid, consumer always ready.
        @(negedge clk);
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            expect_grant("rr", RR_SEQ[c]);
            @(negedge clk);
        end
        req_valid = 4'h0;
        #1;
        check_vec("rr_noreq", 64'(req_ready), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        check_vec("rr_rspv", 64'(rsp_valid), 64'd0);
        check_vec("rr_busy", 64'(busy), 64'd0);
        check_vec("rr_left", 64'(exp_q.size()), 64'd0);

        // Backpressure: four transfers fill the credit, then stall.
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 4'hF;
        for (int c = 0; c < 4; c++) begin
            expect_grant("bp", RR_SEQ[c]);
            @(negedge clk);
        end
        for (int c = 4; c < 8; c++) begin
            #1;
            check_vec("bp_stall", 64'(req_ready), 64'd0);
            check_vec("bp_busy", 64'(busy), 64'd1);
            check_vec("bp_hold_id", 64'(rsp_id), 64'd1);
            check_vec("bp_hold_v", 64'(rsp_valid), 64'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check_vec("bp_popcycle", 64'(req_ready), 64'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        expect_grant("bp_regrant", 1);
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        check_vec("bp_head_id", 64'(rsp_id), 64'd2);
        check_vec("bp_head_cnt", 64'(rsp_count), 64'd2);
        // Push and pop land on the same edge here.
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check_vec("pp_pcov", 64'(pc_out_valid), 64'd1);
        @(negedge clk); #1;
        check_vec("pp_head_id", 64'(rsp_id), 64'd3);
        check_vec("pp_head_cnt", 64'(rsp_count), 64'd20);
        repeat (3) @(negedge clk);
        #1;
        check_vec("pp_rspv", 64'(rsp_valid), 64'd0);
        check_vec("pp_busy", 64'(busy), 64'd0);
        check_vec("pp_left", 64'(exp_q.size()), 64'd0);

        // Unexpected pipeline result sets the sticky error.
        @(negedge clk);
        inj = 1'b1;
        #1;
        check_vec("err_pre", 64'(err), 64'd0);
        @(negedge clk);
        inj = 1'b0;
        #1;
        check_vec("err_set", 64'(err), 64'd1);
        check_vec("err_nopush", 64'(rsp_valid), 64'd0);
        check_vec("err_busy", 64'(busy), 64'd0);
        repeat (2) begin
            @(negedge clk); #1;
            check_vec("err_hold", 64'(err), 64'd1);
        end
        @(negedge clk);
        req_valid = 4'b0001;
        expect_grant("err_req", 0);
        @(negedge clk);
        req_valid = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        check_vec("err_rspv", 64'(rsp_valid), 64'd0);
        check_vec("err_left", 64'(exp_q.size()), 64'd0);
        check_vec("err_still", 64'(err), 64'd1);

        // Reset with two in flight and two buffered.
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 4'hF;
        for (int c = 0; c < 4; c++) begin
            expect_grant("mid", RR_SEQ[c]);
            @(negedge clk);
        end
        #1;
        check_vec("mid_stall", 64'(req_ready), 64'd0);
        check_vec("mid_rspv", 64'(rsp_valid), 64'd1);
        check_vec("mid_err", 64'(err), 64'd1);
        RST = 1'b1;
        exp_q.delete();
        #1;
        check_vec("mrst_rspv", 64'(rsp_valid), 64'd0);
        check_vec("mrst_busy", 64'(busy), 64'd0);
        check_vec("mrst_err", 64'(err), 64'd0);
        check_vec("mrst_ready", 64'(req_ready), 64'd0);
        check_vec("mrst_pcv", 64'(pc_in_valid), 64'd0);
        @(negedge clk);
        RST = 1'b0;
        expect_grant("post", 0);
        @(negedge clk);
        req_valid = 4'h0; rsp_ready = 1'b1;
        #1;
        check_vec("post_err", 64'(err), 64'd0);
        check_vec("post_rspv1", 64'(rsp_valid), 64'd0);
        @(negedge clk); #1;
        check_vec("post_rspv2", 64'(rsp_valid), 64'd0);
        @(negedge clk); #1;
        check_vec("post_rspv3", 64'(rsp_valid), 64'd1);
        @(negedge clk); #1;
        check_vec("post_idle", 64'(busy), 64'd0);
        check_vec("post_err2", 64'(err), 64'd0);
        check_vec("post_left", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
